// File: rtl/mod_chain_counter.sv
// mod_chain_counter: a chain of DIGITS cascaded modulo counter digits.
// Each digit has its own modulus. The chain counts up or down, with
// synchronous clear, parallel load, CTp/CTt enables and carry out CO.
// Optional macro MCC_LDCHK_EN: when defined, any loaded digit that is
// >= its modulus is forced to 0. When undefined, D is loaded verbatim.

// One counter digit: clear, load, or step.
// It reports whether it is at its terminal value for the current direction.
module mod_chain_digit #(
    parameter int                 DIGIT_W = 4,
    // A field value of 0 encodes the full 2^DIGIT_W modulus.
    parameter logic [DIGIT_W-1:0] MODF    = 4'd10
) (
    input  logic               clk,
    input  logic               cr,
    input  logic               ld,
    input  logic               step,
    input  logic               ud,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q,
    output logic               term
);
    localparam logic [DIGIT_W:0]   MODV = (MODF == '0) ? (DIGIT_W+1)'(1 << DIGIT_W)
                                                       : {1'b0, MODF};
    localparam logic [DIGIT_W:0]   MAXW = MODV - 1'b1;
    localparam logic [DIGIT_W-1:0] MAXQ = MAXW[DIGIT_W-1:0];

    logic [DIGIT_W-1:0] dload;
    logic [DIGIT_W-1:0] nxt;

    // Load value. Out-of-range digits are zeroed only when the check is built in.
    always_comb begin
`ifdef MCC_LDCHK_EN
        dload = ({1'b0, d} >= MODV) ? '0 : d;
`else
        dload = d;
`endif
    end

    // Terminal test and next count value.
    // In up mode, an out-of-range digit counts as terminal, so it wraps to 0.
    always_comb begin
        term = ud ? (q >= MAXQ) : (q == '0);
        nxt  = '0;
        if (ud)
            nxt = (q >= MAXQ) ? '0 : q + 1'b1;
        else
            nxt = (q == '0) ? MAXQ : q - 1'b1;
    end

    // Digit register. Clear has priority over load, and load over step.
    always_ff @(posedge clk) begin
        if (cr)
            q <= '0;
        else if (ld)
            q <= dload;
        else if (step)
            q <= nxt;
    end
endmodule

module mod_chain_counter #(
    parameter int                        DIGIT_W = 4,
    parameter int                        DIGITS  = 2,
    parameter logic [DIGITS*DIGIT_W-1:0] MODS    = {4'd6, 4'd10}
) (
    input  logic                      CP,
    input  logic                      CR,
    input  logic                      NotLD,
    input  logic                      CTp,
    input  logic                      CTt,
    input  logic                      UD,
    input  logic [DIGITS*DIGIT_W-1:0] D,
    output logic [DIGITS*DIGIT_W-1:0] Q,
    output logic                      CO
);
    logic [DIGITS-1:0][DIGIT_W-1:0] d_dig;
    logic [DIGITS-1:0][DIGIT_W-1:0] q_dig;
    logic [DIGITS-1:0]              term;
    logic [DIGITS:0]                below_term;   // below_term[i]: all digits j<i are terminal
    logic                           cnt_en;

    assign d_dig  = D;
    assign Q      = q_dig;
    assign cnt_en = CTp & CTt;

    // Ripple the enable chain.
    // A digit steps only when every lower digit is wrapping.
    always_comb begin
        below_term[0] = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            below_term[i+1] = below_term[i] & term[i];
    end

    // CO depends only on CTt and the terminal flags, so cascades ripple combinationally.
    assign CO = CTt & below_term[DIGITS];

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            mod_chain_digit #(
                .DIGIT_W (DIGIT_W),
                .MODF    (MODS[g*DIGIT_W +: DIGIT_W])
            ) u_dig (
                .clk  (CP),
                .cr   (CR),
                .ld   (~NotLD),
                .step (cnt_en & below_term[g]),
                .ud   (UD),
                .d    (d_dig[g]),
                .q    (q_dig[g]),
                .term (term[g])
            );
        end
    endgenerate
endmodule

// File: tb/tb_mod_chain_counter.sv
// Directed test of mod_chain_counter with the default 00-59 configuration.
module tb_mod_chain_counter;
    logic       CP = 1'b0;
    logic       CR, NotLD, CTp, CTt, UD;
    logic [7:0] D;
    logic [7:0] Q;
    logic       CO;
    int         total = 0;
    int         bad = 0;

    mod_chain_counter dut (
        .CP(CP), .CR(CR), .NotLD(NotLD), .CTp(CTp), .CTt(CTt),
        .UD(UD), .D(D), .Q(Q), .CO(CO)
    );

    always #10 CP = ~CP;

    task automatic edge1();
        @(posedge CP);
        #1;
    endtask

    task automatic test_reset();
        CR = 1; NotLD = 1; CTp = 0; CTt = 1; UD = 1; D = 8'h00;
        edge1(); edge1();
        total++; if (Q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", Q); end
        total++; if (CO !== 1'b0) begin bad++; $display("FAIL reset_co_up got=%b exp=0", CO); end
        UD = 0; #1;
        total++; if (CO !== 1'b1) begin bad++; $display("FAIL reset_co_down got=%b exp=1", CO); end
        CR = 0;
    endtask

    task automatic test_up_wrap();
        logic [7:0] exp_q [3] = '{8'h58, 8'h59, 8'h00};
        logic       exp_c [3] = '{1'b0, 1'b1, 1'b0};
        NotLD = 0; D = 8'h57; CTp = 0; CTt = 0; UD = 1;
        edge1();
        total++; if (Q !== 8'h57) begin bad++; $display("FAIL up_load got=%h exp=57", Q); end
        NotLD = 1; CTp = 1; CTt = 1;
        for (int i = 0; i < 3; i++) begin
            edge1();
            total++; if (Q !== exp_q[i]) begin bad++; $display("FAIL up_q%0d got=%h exp=%h", i, Q, exp_q[i]); end
            total++; if (CO !== exp_c[i]) begin bad++; $display("FAIL up_co%0d got=%b exp=%b", i, CO, exp_c[i]); end
        end
    endtask

    task automatic test_down_borrow();
        NotLD = 0; D = 8'h10; UD = 0; CTp = 1; CTt = 1;
        edge1();
        total++; if (Q !== 8'h10) begin bad++; $display("FAIL dn_load got=%h exp=10", Q); end
        NotLD = 1;
        edge1();
        total++; if (Q !== 8'h09) begin bad++; $display("FAIL dn_q09 got=%h exp=09", Q); end
        edge1();
        total++; if (Q !== 8'h08) begin bad++; $display("FAIL dn_q08 got=%h exp=08", Q); end
        NotLD = 0; D = 8'h00;
        edge1();
        total++; if (CO !== 1'b1) begin bad++; $display("FAIL dn_co0 got=%b exp=1", CO); end
        NotLD = 1;
        edge1();
        total++; if (Q !== 8'h59) begin bad++; $display("FAIL dn_wrap got=%h exp=59", Q); end
        total++; if (CO !== 1'b0) begin bad++; $display("FAIL dn_co59 got=%b exp=0", CO); end
    endtask

    task automatic test_enable_gating();
        NotLD = 0; D = 8'h59; UD = 1;
        edge1();
        NotLD = 1; CTp = 0; CTt = 1;
        edge1();
        total++; if (Q !== 8'h59) begin bad++; $display("FAIL gate_ctp_q got=%h exp=59", Q); end
        total++; if (CO !== 1'b1) begin bad++; $display("FAIL gate_ctp_co got=%b exp=1", CO); end
        CTp = 1; CTt = 0;
        edge1();
        total++; if (Q !== 8'h59) begin bad++; $display("FAIL gate_ctt_q got=%h exp=59", Q); end
        total++; if (CO !== 1'b0) begin bad++; $display("FAIL gate_ctt_co got=%b exp=0", CO); end
    endtask

    task automatic test_priority();
        CR = 1; NotLD = 0; D = 8'h33; CTp = 1; CTt = 1; UD = 1;
        edge1();
        total++; if (Q !== 8'h00) begin bad++; $display("FAIL prio_clr got=%h exp=00", Q); end
        CR = 0;
        edge1();
        total++; if (Q !== 8'h33) begin bad++; $display("FAIL prio_ld got=%h exp=33", Q); end
        D = 8'h41;
        edge1();
        NotLD = 1;
        edge1();
        total++; if (Q !== 8'h42) begin bad++; $display("FAIL prio_cnt got=%h exp=42", Q); end
        CR = 1;
        edge1();
        total++; if (Q !== 8'h00) begin bad++; $display("FAIL prio_clrcnt got=%h exp=00", Q); end
        CR = 0;
        edge1();
        total++; if (Q !== 8'h01) begin bad++; $display("FAIL prio_restart got=%h exp=01", Q); end
    endtask

    task automatic test_load_range();
        NotLD = 0; D = 8'h7C; CTp = 1; CTt = 1; UD = 1;
        edge1();
        NotLD = 1;
`ifdef MCC_LDCHK_EN
        total++; if (Q !== 8'h00) begin bad++; $display("FAIL ldchk_q got=%h exp=00", Q); end
`else
        total++; if (Q !== 8'h7C) begin bad++; $display("FAIL ldraw_q got=%h exp=7c", Q); end
        total++; if (CO !== 1'b1) begin bad++; $display("FAIL ldraw_co got=%b exp=1", CO); end
        edge1();
        total++; if (Q !== 8'h00) begin bad++; $display("FAIL ldraw_wrap got=%h exp=00", Q); end
`endif
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_borrow();
        test_enable_gating();
        test_priority();
        test_load_range();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mod_chain_counter.md
# mod_chain_counter

Parametrised successor to the single-stage 4-bit synchronous counter: a chain of DIGITS cascaded counter digits, each with its own modulus, counting up or down, with parallel load and 161-style CTp/CTt enables and carry-out. It is the time-keeping core of the clock designs, for example seconds and minutes as 00–59 BCD, or hours as 00–23. Several instances cascade through CO into CTt.

## Interface
Parameters:
- DIGIT_W, 4: bits per digit.
- DIGITS, 2: number of cascaded digits; digit 0 is least significant.
- MODS, {4'd6, 4'd10}: packed moduli, DIGITS*DIGIT_W bits. Digit i uses MODS[i*DIGIT_W +: DIGIT_W]. Each modulus is in the range 2..2^DIGIT_W.

Ports (the single clock is CP; reset is synchronous and active-high):
- CP  in  1  clock; all state changes on the rising edge.
- CR  in  1  synchronous active-high clear.
- NotLD  in  1  synchronous active-low parallel load.
- CTp  in  1  count enable; does not gate CO.
- CTt  in  1  count enable; gates CO (cascade input).
- UD  in  1  direction: 1 = up, 0 = down.
- D  in  DIGITS*DIGIT_W  parallel load data, same digit packing as Q.
- Q  out  DIGITS*DIGIT_W  registered count.
- CO  out  1  combinational terminal-count / carry out.

## Operation
Priority at each rising CP edge:
- CR=1 → Q=0.
- Else NotLD=0 → Q=D. Out-of-range handling is set by the macro below.
- Else CTp & CTt = 1 → count.
- Else hold.

Digit terminal condition, per digit i:
- Up: Q_i ≥ MOD_i−1.
- Down: Q_i = 0.

Counting:
- Digit i steps when counting is enabled and every digit j<i is at terminal. Digit 0 always steps when counting.
- Up step: a terminal digit wraps to 0; otherwise it increments.
- Down step: a digit at 0 wraps to MOD_i−1; otherwise it decrements.

CO = CTt & (all digits at terminal, per the current UD). CO is independent of CTp, NotLD and CR.

Boundary conditions:
- Full wrap: up from all-terminal gives all 0; down from all 0 gives all MOD_i−1.
- UD changes between edges: the next edge uses the new direction, and CO follows UD combinationally.
- Out-of-range digit (only reachable without the macro): counting up treats it as terminal and wraps it to 0. Counting down decrements it normally until it is back in range.
- CR mid-count or during load: clear wins; the count restarts from 0 on the following edges.
- All arithmetic is per digit, modulo its own modulus. No digit carries into another except through the enable chain.

## Timing
- Reset values: Q=0. CO = CTt & ~UD, because all-zero is terminal in down mode.
- Q updates one edge after the controlling inputs; load-to-Q latency is 1 cycle.
- CO is combinational from Q, UD and CTt, with no register stage. A cascaded instance whose CTt is driven by this CO and whose CTp is tied high advances on the same edge at which this instance wraps.
- There are no multi-cycle operations and no handshake; every cycle stands alone.

## Configuration
Macro MCC_LDCHK_EN:
- Defined: during load, any digit with D_i ≥ MOD_i is replaced by 0, so Q is always in range.
- Undefined: D is loaded verbatim, and out-of-range digits behave as described under Operation. This option has no extra logic and is for tests and preset tricks.

## Test plan
All scenarios use the default parameters (00–59) and a 20 ns CP period.
- Reset: CR=1 for 2 edges, with UD=1 and CTt=1 → Q=8'h00, CO=0. Then set UD=0 → CO=1 immediately.
- Up count and wrap: NotLD=0 with D=8'h57 for one edge → Q=8'h57. Then NotLD=1, CTp=CTt=1, UD=1 → Q=58, 59 (CO=1 while at 59), then 00 (CO=0).
- Down count and borrow: load 8'h10, UD=0, count → Q=10, 09, 08. Then load 8'h00 → CO=1, and the next edge gives Q=8'h59.
- Enable gating at Q=59 with UD=1:
  - CTp=0, CTt=1 → Q holds, CO=1.
  - CTp=1, CTt=0 → Q holds, CO=0.
- Priority: CR=1 with NotLD=0 and D=8'h33 → Q=00. NotLD=0 with D=8'h33 and CTp=CTt=1 → Q=33, not 34. CR=1 asserted while counting at 8'h42 → next edge Q=00.
- Macro: load D=8'h7C.
  - With MCC_LDCHK_EN → Q=8'h00.
  - Without it → Q=8'h7C, and one up-count edge gives Q=8'h00.
